apb3_wait_reg_slave: RTL and testbench
======================================

Name: apb3_wait_reg_slave

Overview:
- APB3 completer (slave) for the APB side of the AHB-to-APB3 bridge.
- Contains NUM_REGS read/write 32-bit registers, a read-only ID word and a read-only write counter.
- Inserts a programmable number of wait states through PREADY and reports decode errors on PSLVERR.
- Register contents are exported to fabric logic. Used as a bridge test target and as a general control-register block.

Parameters:
- ADDR_WIDTH, 24, PADDR width; full address is decoded.
- NUM_REGS, 8, number of R/W registers (1..16).
- WAIT_STATES, 1, PREADY-low cycles inserted in the access phase (0..15).
- ID_VALUE, 32'hA3B0_0001, constant returned by the ID word.

Ports:
- HCLK  in  1  clock; all logic rising-edge.
- HRESET  in  1  asynchronous, active-high reset.
- PSEL  in  1  slave select.
- PENABLE  in  1  access-phase strobe.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_WIDTH  byte address.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data; valid only while PREADY=1.
- PREADY  out  1  transfer completion.
- PSLVERR  out  1  error; meaningful only while PREADY=1.
- REG_OUT  out  32*NUM_REGS  flattened register contents; reg i is bits [32i+31:32i].

Behaviour:
- Reset (asynchronous, while HRESET=1): state=IDLE, PREADY=0, PSLVERR=0, PRDATA=0, all registers=0, write counter=0.
- Address map (word aligned):
  - 4*i for i<NUM_REGS: REG[i], R/W.
  - 4*NUM_REGS: ID word, RO, returns ID_VALUE.
  - 4*NUM_REGS+4: WRCNT, RO, 32-bit count of successful writes; wraps FFFF_FFFF -> 0.
  - Any other address, or PADDR[1:0]!=0: error.
- State machine states: IDLE, WAIT, DONE.
  - IDLE: on PSEL=1 & PENABLE=0 (setup phase), latch PADDR/PWRITE/PWDATA and load the wait counter with WAIT_STATES.
  - IDLE -> WAIT on the setup phase when WAIT_STATES>0; IDLE -> DONE when WAIT_STATES=0.
  - WAIT: PREADY=0; counter decrements each cycle PSEL=1 & PENABLE=1. Counter reaching 1 -> DONE next cycle.
  - DONE: PREADY, PSLVERR and PRDATA are registered outputs, asserted in the cycle after entry. Return to IDLE after one cycle.
- Latency: with the setup phase at cycle 0, the access phase starts at cycle 1 and PREADY=1 in cycle 1+WAIT_STATES. WAIT_STATES=0 gives a zero-wait transfer.
- PREADY is high for exactly one cycle per transfer and is 0 in IDLE. PSLVERR and PRDATA are forced to 0 whenever PREADY=0.
- Write commit: happens on the PREADY=1 cycle, only when there is no error. On commit, the target REG is updated and WRCNT increments by 1.
- Errors: writes to ID or WRCNT, and unmapped or misaligned accesses, return PSLVERR=1 with PREADY. Register state is unchanged and WRCNT does not increment. An errored read returns PRDATA=0.
- Reads: PRDATA is sampled from the register state at the start of the access phase. REG_OUT updates in the cycle after commit.
- Back-to-back: a new setup phase in the cycle after the PREADY=1 cycle is accepted with no idle cycle.
- Abort: if PSEL drops while in WAIT, return to IDLE with no commit, no PREADY and no counter change.
- PENABLE=1 seen in IDLE (no setup phase): ignored; the block stays in IDLE.
- Reset mid-transfer: the transfer is discarded and all state returns to reset values immediately.

Test Plan:
- Reset with WAIT_STATES=1: PREADY=0, PRDATA=0, REG_OUT=0. Read 4*NUM_REGS (0x20) -> PREADY high in cycle 2 after setup, PRDATA=A3B00001, PSLVERR=0.
- Write 0x04 <- DEADBEEF, then read 0x04 -> PRDATA=DEADBEEF, REG_OUT[63:32]=DEADBEEF. WRCNT at 0x24 reads 1.
- Write 0x20 <- 1234, write 0x28, read 0x06 -> PSLVERR=1 each time, REG_OUT unchanged, WRCNT still 1, error reads return PRDATA=0.
- WAIT_STATES=0 and 3 builds: PREADY is asserted 1 and 4 cycles after setup respectively. Four back-to-back writes to 0x00..0x0C all commit and WRCNT reads 4.
- Drop PSEL during WAIT of a write to 0x08 (WAIT_STATES=3) -> no PREADY, REG[2] unchanged. The next full transfer completes normally.
- Assert HRESET in a WAIT cycle -> outputs zero in the same cycle and REG_OUT=0. A transfer after release completes normally.

Source files
------------

// File: rtl/apb3_wait_reg_slave.sv
// rtl/apb3_wait_reg_slave.sv - APB3 register completer with programmable wait states
// R/W register file plus read-only ID and write-counter words; decode errors on PSLVERR.
module apb3_wait_reg_slave #(
  parameter int          ADDR_WIDTH  = 24,
  parameter int          NUM_REGS    = 8,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] ID_VALUE    = 32'hA3B0_0001
) (
  input  logic                     HCLK,
  input  logic                     HRESET,
  input  logic                     PSEL,
  input  logic                     PENABLE,
  input  logic                     PWRITE,
  input  logic [ADDR_WIDTH-1:0]    PADDR,
  input  logic [31:0]              PWDATA,
  output logic [31:0]              PRDATA,
  output logic                     PREADY,
  output logic                     PSLVERR,
  output logic [32*NUM_REGS-1:0]   REG_OUT
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [ADDR_WIDTH-3:0] ID_IDX  = (ADDR_WIDTH-2)'(NUM_REGS);
  localparam logic [ADDR_WIDTH-3:0] CNT_IDX = ID_IDX + 1'b1;
  localparam logic [3:0]            WS      = 4'(WAIT_STATES);

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [31:0]           prdata_q, prdata_d;
  logic [31:0]           regs_q [NUM_REGS];
  logic [31:0]           wrcnt_q;

  logic [ADDR_WIDTH-1:0] dec_addr;
  logic [ADDR_WIDTH-3:0] dec_widx;
  logic                  dec_write;
  logic                  dec_err;
  logic [31:0]           dec_rdata;
  logic                  enter_done;
  logic                  commit;

  // A zero-wait transfer enters DONE on the setup edge, so decode straight off the bus in IDLE.
  assign dec_addr  = (state_q == IDLE) ? PADDR : addr_q;
  assign dec_write = (state_q == IDLE) ? PWRITE : write_q;
  assign dec_widx  = dec_addr[ADDR_WIDTH-1:2];

  always_comb begin
    dec_err   = 1'b1;
    dec_rdata = 32'h0;
    if (dec_addr[1:0] == 2'b00) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (dec_widx == (ADDR_WIDTH-2)'(i)) begin
          dec_err   = 1'b0;
          dec_rdata = regs_q[i];
        end
      end
      if (dec_widx == ID_IDX) begin
        dec_err   = dec_write;
        dec_rdata = ID_VALUE;
      end
      if (dec_widx == CNT_IDX) begin
        dec_err   = dec_write;
        dec_rdata = wrcnt_q;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    enter_done = 1'b0;
    pready_d   = 1'b0;
    pslverr_d  = 1'b0;
    prdata_d   = 32'h0;
    case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          addr_d  = PADDR;
          write_d = PWRITE;
          wdata_d = PWDATA;
          cnt_d   = WS;
          if (WS == 4'd0) begin
            state_d    = DONE;
            enter_done = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!PSEL) begin
          state_d = IDLE;
        end else if (PENABLE) begin
          if (cnt_q <= 4'd1) begin
            state_d    = DONE;
            enter_done = 1'b1;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (enter_done) begin
      pready_d  = 1'b1;
      pslverr_d = dec_err;
      prdata_d  = (dec_err || dec_write) ? 32'h0 : dec_rdata;
    end
  end

  // pslverr_q is live during DONE, so it doubles as the commit veto.
  assign commit = (state_q == DONE) && write_q && !pslverr_q;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= 32'h0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= 32'h0;
      wrcnt_q   <= 32'h0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 32'h0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      if (commit) begin
        wrcnt_q <= wrcnt_q + 32'd1;
        for (int i = 0; i < NUM_REGS; i++) begin
          if (addr_q[ADDR_WIDTH-1:2] == (ADDR_WIDTH-2)'(i)) regs_q[i] <= wdata_q;
        end
      end
    end
  end

  always_comb begin
    REG_OUT = '0;
    for (int i = 0; i < NUM_REGS; i++) REG_OUT[32*i +: 32] = regs_q[i];
  end

  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;
  assign PRDATA  = prdata_q;

endmodule

// File: tb/tb_apb3_wait_reg_slave.sv
// tb/tb_apb3_wait_reg_slave.sv - directed bench for apb3_wait_reg_slave
// Three instances (0, 1 and 3 wait states) share the bus; sel picks the addressed one.
module tb_apb3_wait_reg_slave;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        psel = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PWRITE = 1'b0;
  logic [23:0] PADDR = 24'h0;
  logic [31:0] PWDATA = 32'h0;
  int          sel = 1;

  logic        ps0, ps1, ps3;
  logic [31:0] prdata0, prdata1, prdata3, prdata_m;
  logic        pready0, pready1, pready3, pready_m;
  logic        pslverr0, pslverr1, pslverr3, pslverr_m;
  logic [255:0] regout0, regout1, regout3, regout_m;

  int vectors = 0;
  int miscompares = 0;

  always #5 HCLK = ~HCLK;

  assign ps0 = psel && (sel == 0);
  assign ps1 = psel && (sel == 1);
  assign ps3 = psel && (sel == 3);

  always_comb begin
    prdata_m = prdata1; pready_m = pready1; pslverr_m = pslverr1; regout_m = regout1;
    if (sel == 0) begin
      prdata_m = prdata0; pready_m = pready0; pslverr_m = pslverr0; regout_m = regout0;
    end else if (sel == 3) begin
      prdata_m = prdata3; pready_m = pready3; pslverr_m = pslverr3; regout_m = regout3;
    end
  end

  apb3_wait_reg_slave #(.WAIT_STATES(0)) u_ws0 (
    .HCLK(HCLK), .HRESET(HRESET), .PSEL(ps0), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata0), .PREADY(pready0),
    .PSLVERR(pslverr0), .REG_OUT(regout0));

  apb3_wait_reg_slave #(.WAIT_STATES(1)) u_ws1 (
    .HCLK(HCLK), .HRESET(HRESET), .PSEL(ps1), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata1), .PREADY(pready1),
    .PSLVERR(pslverr1), .REG_OUT(regout1));

  apb3_wait_reg_slave #(.WAIT_STATES(3)) u_ws3 (
    .HCLK(HCLK), .HRESET(HRESET), .PSEL(ps3), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata3), .PREADY(pready3),
    .PSLVERR(pslverr3), .REG_OUT(regout3));

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Setup phase, then access phase until PREADY; returns at the negedge of the PREADY cycle.
  task automatic xfer(input int s, input logic wr, input logic [23:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic err, output int lat);
    logic done;
    @(posedge HCLK); #1;
    sel = s; psel = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d;
    rd = 32'h0; err = 1'b0; done = 1'b0;
    @(posedge HCLK); #1;
    PENABLE = 1'b1;
    lat = 1;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge HCLK);
      if (pready_m === 1'b1) begin
        rd = prdata_m;
        err = pslverr_m;
        done = 1'b1;
      end else begin
        @(posedge HCLK); #1;
        lat++;
      end
    end
    if (!done) begin
      lat = -1;
      vectors++;
      assert (done) else begin
        miscompares++;
        $error("FAIL timeout: observed no PREADY expected PREADY within 40 cycles");
      end
    end
  endtask

  task automatic idle();
    @(posedge HCLK); #1;
    psel = 1'b0; PENABLE = 1'b0;
  endtask

  logic [31:0]  rd;
  logic         err;
  int           lat;
  int           hits;
  int           bad_lat;
  logic         any_err;
  logic [255:0] e;

  initial begin
    repeat (3) @(posedge HCLK);
    #1 HRESET = 1'b0;
    #1;
    check("reset_pready", 256'(pready1), 256'(0));
    check("reset_prdata", 256'(prdata1), 256'(0));
    check("reset_regout", regout1, 256'(0));

    xfer(1, 1'b0, 24'h20, 32'h0, rd, err, lat);
    check("id_lat", 256'(lat), 256'(2));
    check("id_data", 256'(rd), 256'(32'hA3B0_0001));
    check("id_err", 256'(err), 256'(0));

    xfer(1, 1'b1, 24'h04, 32'hDEAD_BEEF, rd, err, lat);
    check("wr04_err", 256'(err), 256'(0));
    check("wr04_lat", 256'(lat), 256'(2));
    xfer(1, 1'b0, 24'h04, 32'h0, rd, err, lat);
    check("rd04_data", 256'(rd), 256'(32'hDEAD_BEEF));
    idle();
    e = '0; e[63:32] = 32'hDEAD_BEEF;
    check("regout_wr04", regout1, e);
    xfer(1, 1'b0, 24'h24, 32'h0, rd, err, lat);
    check("wrcnt_1", 256'(rd), 256'(1));

    xfer(1, 1'b1, 24'h20, 32'h0000_1234, rd, err, lat);
    check("wr_id_err", 256'(err), 256'(1));
    xfer(1, 1'b1, 24'h28, 32'h0000_5678, rd, err, lat);
    check("wr_unmapped_err", 256'(err), 256'(1));
    xfer(1, 1'b0, 24'h06, 32'h0, rd, err, lat);
    check("rd_misaligned_err", 256'(err), 256'(1));
    check("rd_misaligned_data", 256'(rd), 256'(0));
    xfer(1, 1'b0, 24'h28, 32'h0, rd, err, lat);
    check("rd_unmapped_data", 256'(rd), 256'(0));
    idle();
    check("regout_after_err", regout1, e);
    xfer(1, 1'b0, 24'h24, 32'h0, rd, err, lat);
    check("wrcnt_still_1", 256'(rd), 256'(1));
    idle();

    @(posedge HCLK); #1;
    sel = 0; psel = 1'b1; PENABLE = 1'b1; PADDR = 24'h20; PWRITE = 1'b0;
    hits = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge HCLK);
      if (pready_m !== 1'b0) hits++;
    end
    check("penable_in_idle", 256'(hits), 256'(0));
    idle();

    xfer(0, 1'b0, 24'h20, 32'h0, rd, err, lat);
    check("ws0_lat", 256'(lat), 256'(1));
    check("ws0_id", 256'(rd), 256'(32'hA3B0_0001));
    idle();
    xfer(3, 1'b0, 24'h20, 32'h0, rd, err, lat);
    check("ws3_lat", 256'(lat), 256'(4));
    idle();

    bad_lat = 0; any_err = 1'b0;
    for (int i = 0; i < 4; i++) begin
      xfer(0, 1'b1, 24'(4 * i), 32'h1000_0000 + 32'(i), rd, err, lat);
      if (lat != 1) bad_lat++;
      any_err = any_err | err;
    end
    xfer(0, 1'b0, 24'h24, 32'h0, rd, err, lat);
    check("ws0_b2b_lat", 256'(bad_lat), 256'(0));
    check("ws0_b2b_err", 256'(any_err), 256'(0));
    check("ws0_wrcnt_4", 256'(rd), 256'(4));
    idle();

    bad_lat = 0; any_err = 1'b0;
    for (int i = 0; i < 4; i++) begin
      xfer(3, 1'b1, 24'(4 * i), 32'h1000_0000 + 32'(i), rd, err, lat);
      if (lat != 4) bad_lat++;
      any_err = any_err | err;
    end
    xfer(3, 1'b0, 24'h24, 32'h0, rd, err, lat);
    check("ws3_b2b_lat", 256'(bad_lat), 256'(0));
    check("ws3_b2b_err", 256'(any_err), 256'(0));
    check("ws3_wrcnt_4", 256'(rd), 256'(4));
    idle();
    e = '0;
    e[127:0] = 128'h1000_0003_1000_0002_1000_0001_1000_0000;
    check("ws0_regout", regout0, e);
    check("ws3_regout", regout3, e);

    @(posedge HCLK); #1;
    sel = 3; psel = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 24'h08; PWDATA = 32'h5555_5555;
    hits = 0;
    @(negedge HCLK); if (pready_m !== 1'b0) hits++;
    @(posedge HCLK); #1 PENABLE = 1'b1;
    @(negedge HCLK); if (pready_m !== 1'b0) hits++;
    @(posedge HCLK); #1 psel = 1'b0; PENABLE = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge HCLK);
      if (pready_m !== 1'b0) hits++;
    end
    check("abort_no_pready", 256'(hits), 256'(0));
    check("abort_reg2", 256'(regout3[95:64]), 256'(32'h1000_0002));
    xfer(3, 1'b0, 24'h08, 32'h0, rd, err, lat);
    check("after_abort_lat", 256'(lat), 256'(4));
    check("after_abort_data", 256'(rd), 256'(32'h1000_0002));
    xfer(3, 1'b0, 24'h24, 32'h0, rd, err, lat);
    check("after_abort_wrcnt", 256'(rd), 256'(4));
    idle();

    @(posedge HCLK); #1;
    sel = 3; psel = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 24'h08;
    @(posedge HCLK); #1 PENABLE = 1'b1;
    @(posedge HCLK); #1 HRESET = 1'b1;
    #1;
    check("rst_mid_pready", 256'(pready_m), 256'(0));
    check("rst_mid_prdata", 256'(prdata_m), 256'(0));
    check("rst_mid_regout3", regout3, 256'(0));
    check("rst_mid_regout1", regout1, 256'(0));
    @(posedge HCLK); #1;
    HRESET = 1'b0; psel = 1'b0; PENABLE = 1'b0;

    xfer(3, 1'b0, 24'h24, 32'h0, rd, err, lat);
    check("post_rst_wrcnt", 256'(rd), 256'(0));
    check("post_rst_lat", 256'(lat), 256'(4));
    xfer(3, 1'b1, 24'h08, 32'hCAFE_F00D, rd, err, lat);
    check("post_rst_wr_err", 256'(err), 256'(0));
    xfer(3, 1'b0, 24'h08, 32'h0, rd, err, lat);
    check("post_rst_rd", 256'(rd), 256'(32'hCAFE_F00D));
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
